// File: rtl/cmd_pkg.sv
// rtl/cmd_pkg.sv - shared command encoding, player states and grid defaults
package cmd_pkg;

  typedef enum logic [1:0] {
    CMD_UP    = 2'b00,
    CMD_DOWN  = 2'b01,
    CMD_LEFT  = 2'b10,
    CMD_RIGHT = 2'b11
  } cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_EXEC,
    ST_DONE
  } player_state_t;

  localparam int DEF_ADDR_W       = 8;
  localparam int DEF_POS_W        = 4;
  localparam int DEF_GRID_MAX     = 15;
  localparam int DEF_START_X      = 7;
  localparam int DEF_START_Y      = 7;
  localparam int DEF_READ_LATENCY = 2;

endpackage

// File: rtl/grid_stepper.sv
// rtl/grid_stepper.sv - saturating one-cell cursor move on a 0..GRID_MAX grid
module grid_stepper
  import cmd_pkg::*;
#(
  parameter int POS_W    = DEF_POS_W,
  parameter int GRID_MAX = DEF_GRID_MAX
) (
  input  logic [POS_W-1:0] pos_x,
  input  logic [POS_W-1:0] pos_y,
  input  cmd_t             cmd,
  output logic [POS_W-1:0] next_x,
  output logic [POS_W-1:0] next_y
);

  localparam logic [POS_W-1:0] MAX_POS = POS_W'(GRID_MAX);

  // A blocked move leaves the coordinate where it is.
  always_comb begin
    next_x = pos_x;
    next_y = pos_y;
    case (cmd)
      CMD_UP:    if (pos_y != '0)     next_y = pos_y - 1'b1;
      CMD_DOWN:  if (pos_y < MAX_POS) next_y = pos_y + 1'b1;
      CMD_LEFT:  if (pos_x != '0)     next_x = pos_x - 1'b1;
      CMD_RIGHT: if (pos_x < MAX_POS) next_x = pos_x + 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/command_player.sv
// rtl/command_player.sv - replays stored direction commands onto a grid cursor
module command_player
  import cmd_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int POS_W        = DEF_POS_W,
  parameter int GRID_MAX     = DEF_GRID_MAX,
  parameter int START_X      = DEF_START_X,
  parameter int START_Y      = DEF_START_Y,
  parameter int READ_LATENCY = DEF_READ_LATENCY
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] num_commands,
  input  logic              step_tick,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [1:0]        rd_data,
  output logic [POS_W-1:0]  pos_x,
  output logic [POS_W-1:0]  pos_y,
  output logic [1:0]        dir,
  output logic              dir_valid,
  output logic [ADDR_W-1:0] step_index,
  output logic              busy,
  output logic              done
);

  localparam int LAT_W = $clog2(READ_LATENCY + 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LATENCY - 1);
  localparam logic [POS_W-1:0] START_X_P = POS_W'(START_X);
  localparam logic [POS_W-1:0] START_Y_P = POS_W'(START_Y);

  player_state_t     state_q, state_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [ADDR_W-1:0] step_q, step_d;
  cmd_t              cmd_q, cmd_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [POS_W-1:0]  pos_x_q, pos_x_d;
  logic [POS_W-1:0]  pos_y_q, pos_y_d;
  logic [1:0]        dir_q, dir_d;
  logic              dir_valid_q, dir_valid_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [POS_W-1:0]  step_x, step_y;

  grid_stepper #(
    .POS_W   (POS_W),
    .GRID_MAX(GRID_MAX)
  ) u_grid_stepper (
    .pos_x (pos_x_q),
    .pos_y (pos_y_q),
    .cmd   (cmd_q),
    .next_x(step_x),
    .next_y(step_y)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    step_d      = step_q;
    cmd_d       = cmd_q;
    lat_d       = lat_q;
    pos_x_d     = pos_x_q;
    pos_y_d     = pos_y_q;
    dir_d       = dir_q;
    dir_valid_d = 1'b0;
    done_d      = (state_q == ST_DONE);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          count_d = num_commands;
          step_d  = '0;
          pos_x_d = START_X_P;
          pos_y_d = START_Y_P;
          state_d = (num_commands != '0) ? ST_FETCH : ST_DONE;
        end
      end
      ST_FETCH: begin
        lat_d   = LAT_W'(1);
        state_d = ST_WAIT;
      end
      // The FSM's rd_en register is the first latency stage; the BRAM q is the rest.
      ST_WAIT: begin
        if (lat_q == LAT_LAST) begin
          cmd_d   = cmd_t'(rd_data);
          state_d = ST_EXEC;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      ST_EXEC: begin
        if (step_tick) begin
          pos_x_d     = step_x;
          pos_y_d     = step_y;
          dir_d       = cmd_q;
          dir_valid_d = 1'b1;
          if (step_q == count_q - ADDR_W'(1)) begin
            state_d = ST_DONE;
          end else begin
            step_d  = step_q + 1'b1;
            state_d = ST_FETCH;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    rd_en_d   = (state_d == ST_FETCH);
    rd_addr_d = (state_d == ST_FETCH) ? step_d : rd_addr_q;
    busy_d    = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      step_q      <= '0;
      cmd_q       <= CMD_UP;
      lat_q       <= '0;
      pos_x_q     <= START_X_P;
      pos_y_q     <= START_Y_P;
      dir_q       <= '0;
      dir_valid_q <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      step_q      <= step_d;
      cmd_q       <= cmd_d;
      lat_q       <= lat_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      dir_q       <= dir_d;
      dir_valid_q <= dir_valid_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign rd_en      = rd_en_q;
  assign rd_addr    = rd_addr_q;
  assign pos_x      = pos_x_q;
  assign pos_y      = pos_y_q;
  assign dir        = dir_q;
  assign dir_valid  = dir_valid_q;
  assign step_index = step_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_command_player.sv
// tb/tb_command_player.sv - directed self-checking bench for command_player
module tb_command_player;

  localparam int RL = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] num_commands = '0;
  logic       step_tick = 1'b0;
  logic       rd_en;
  logic [7:0] rd_addr;
  logic [1:0] rd_data;
  logic [3:0] pos_x, pos_y;
  logic [1:0] dir;
  logic       dir_valid;
  logic [7:0] step_index;
  logic       busy, done;

  int tests = 0;
  int fails = 0;

  logic [1:0] mem [256];
  logic [7:0] addr_log [$];
  int         dv_cnt = 0, done_cnt = 0, rd_double = 0;
  logic       prev_rd_en = 1'b0;

  command_player #(.READ_LATENCY(RL)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .num_commands(num_commands),
    .step_tick(step_tick), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .pos_x(pos_x), .pos_y(pos_y), .dir(dir), .dir_valid(dir_valid),
    .step_index(step_index), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  always @(negedge clk) begin
    if (rd_en) addr_log.push_back(rd_addr);
    if (rd_en && prev_rd_en) rd_double++;
    prev_rd_en = rd_en;
    if (dir_valid) dv_cnt++;
    if (done) done_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] n);
    num_commands = n;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic pulse_tick();
    step_tick = 1'b1;
    cyc(1);
    step_tick = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    cyc(3);
    tests++; if ({pos_x, pos_y} !== 8'h77) begin fails++; $display("FAIL reset_pos got (%0d,%0d) exp (7,7)", pos_x, pos_y); end
    tests++; if ({busy, rd_en, done, dir_valid} !== 4'b0) begin fails++; $display("FAIL reset_flags got busy=%b rd_en=%b done=%b dv=%b exp 0", busy, rd_en, done, dir_valid); end
    tests++; if ({step_index, rd_addr, dir} !== 18'h0) begin fails++; $display("FAIL reset_regs got idx=%0d addr=%0d dir=%0d exp 0", step_index, rd_addr, dir); end
    reset_n = 1'b1;
    cyc(1);
  endtask

  task automatic test_normal();
    logic [3:0] ex [3] = '{4'd8, 4'd9, 4'd9};
    logic [3:0] ey [3] = '{4'd7, 4'd7, 4'd6};
    int a0, dv0, d0, db0;
    mem[0] = 2'b11; mem[1] = 2'b11; mem[2] = 2'b00;
    a0 = addr_log.size(); dv0 = dv_cnt; d0 = done_cnt; db0 = rd_double;
    do_start(8'd3);
    for (int k = 0; k < 3; k++) begin
      cyc(9);
      pulse_tick();
      tests++; if (dir_valid !== 1'b1 || pos_x !== ex[k] || pos_y !== ey[k]) begin
        fails++; $display("FAIL normal_move%0d got dv=%b (%0d,%0d) exp dv=1 (%0d,%0d)", k, dir_valid, pos_x, pos_y, ex[k], ey[k]);
      end
    end
    cyc(1);
    tests++; if (done !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL normal_done got done=%b busy=%b exp done=1 busy=0", done, busy); end
    cyc(2);
    tests++; if (addr_log.size() - a0 != 3) begin fails++; $display("FAIL normal_reads got %0d exp 3", addr_log.size() - a0); end
    else for (int i = 0; i < 3; i++) begin
      tests++; if (addr_log[a0 + i] !== 8'(i)) begin fails++; $display("FAIL normal_addr%0d got %0d exp %0d", i, addr_log[a0 + i], i); end
    end
    tests++; if (rd_double != db0) begin fails++; $display("FAIL normal_rd_pulse got %0d wide pulses exp 0", rd_double - db0); end
    tests++; if (dv_cnt - dv0 != 3 || done_cnt - d0 != 1) begin fails++; $display("FAIL normal_counts got dv=%0d done=%0d exp dv=3 done=1", dv_cnt - dv0, done_cnt - d0); end
    tests++; if (dir !== 2'b00) begin fails++; $display("FAIL normal_dir got %0d exp 0", dir); end
  endtask

  task automatic test_saturation();
    int dv0;
    logic [3:0] ex;
    for (int i = 0; i < 10; i++) mem[i] = 2'b10;
    dv0 = dv_cnt;
    do_start(8'd10);
    for (int k = 0; k < 10; k++) begin
      cyc(4);
      pulse_tick();
      ex = (k < 7) ? 4'(6 - k) : 4'd0;
      tests++; if (pos_x !== ex || pos_y !== 4'd7 || dir !== 2'b10) begin
        fails++; $display("FAIL sat_move%0d got (%0d,%0d) dir=%0d exp (%0d,7) dir=2", k, pos_x, pos_y, dir, ex);
      end
    end
    cyc(1);
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL sat_done got %b exp 1", done); end
    tests++; if (dv_cnt - dv0 != 10) begin fails++; $display("FAIL sat_dv_count got %0d exp 10", dv_cnt - dv0); end
    cyc(1);
  endtask

  task automatic test_zero_count();
    int a0;
    a0 = addr_log.size();
    num_commands = 8'd0;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    tests++; if (done !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL zero_cycle1 got done=%b busy=%b exp done=0 busy=1", done, busy); end
    tests++; if ({pos_x, pos_y} !== 8'h77) begin fails++; $display("FAIL zero_reload got (%0d,%0d) exp (7,7)", pos_x, pos_y); end
    cyc(1);
    tests++; if (done !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL zero_cycle2 got done=%b busy=%b exp done=1 busy=0", done, busy); end
    cyc(1);
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL zero_pulse_width got %b exp 0", done); end
    tests++; if (addr_log.size() != a0) begin fails++; $display("FAIL zero_no_read got %0d reads exp 0", addr_log.size() - a0); end
  endtask

  task automatic test_start_busy();
    int a0;
    mem[0] = 2'b01; mem[1] = 2'b01;
    a0 = addr_log.size();
    do_start(8'd2);
    cyc(2);
    num_commands = 8'd5;
    start = 1'b1;
    cyc(3);
    start = 1'b0;
    tests++; if (step_index !== 8'd0) begin fails++; $display("FAIL busy_start_idx got %0d exp 0", step_index); end
    pulse_tick();
    tests++; if (step_index !== 8'd1 || pos_y !== 4'd8) begin fails++; $display("FAIL busy_step1 got idx=%0d y=%0d exp idx=1 y=8", step_index, pos_y); end
    cyc(4);
    pulse_tick();
    cyc(1);
    tests++; if (done !== 1'b1 || {pos_x, pos_y} !== 8'h79) begin fails++; $display("FAIL busy_end got done=%b (%0d,%0d) exp done=1 (7,9)", done, pos_x, pos_y); end
    tests++; if (addr_log.size() - a0 != 2) begin fails++; $display("FAIL busy_reads got %0d exp 2", addr_log.size() - a0); end
    cyc(1);
  endtask

  task automatic test_tick_timing();
    int elapsed;
    mem[0] = 2'b11;
    do_start(8'd1);
    step_tick = 1'b1;
    cyc(2);
    step_tick = 1'b0;
    tests++; if (dir_valid !== 1'b0 || {pos_x, pos_y} !== 8'h77) begin fails++; $display("FAIL tick_early got dv=%b (%0d,%0d) exp dv=0 (7,7)", dir_valid, pos_x, pos_y); end
    cyc(2);
    tests++; if (dir_valid !== 1'b0) begin fails++; $display("FAIL tick_not_queued got dv=%b exp 0", dir_valid); end
    pulse_tick();
    tests++; if (dir_valid !== 1'b1 || {pos_x, pos_y} !== 8'h87) begin fails++; $display("FAIL tick_exec got dv=%b (%0d,%0d) exp dv=1 (8,7)", dir_valid, pos_x, pos_y); end
    cyc(1);
    tests++; if (dir_valid !== 1'b0 || pos_x !== 4'd8) begin fails++; $display("FAIL tick_single got dv=%b x=%0d exp dv=0 x=8", dir_valid, pos_x); end
    cyc(2);
    do_start(8'd1);
    step_tick = 1'b1;
    elapsed = 0;
    while (dir_valid !== 1'b1 && elapsed < 20) begin
      cyc(1);
      elapsed++;
    end
    step_tick = 1'b0;
    tests++; if (elapsed != RL + 1) begin fails++; $display("FAIL tick_latency got %0d cycles exp %0d", elapsed, RL + 1); end
    cyc(3);
  endtask

  task automatic test_reset_mid();
    int a0;
    mem[0] = 2'b11; mem[1] = 2'b11; mem[2] = 2'b11; mem[3] = 2'b01; mem[4] = 2'b01;
    do_start(8'd5);
    for (int k = 0; k < 2; k++) begin
      cyc(4);
      pulse_tick();
    end
    tests++; if ({pos_x, pos_y} !== 8'h97) begin fails++; $display("FAIL mid_pre got (%0d,%0d) exp (9,7)", pos_x, pos_y); end
    cyc(4);
    reset_n = 1'b0;
    cyc(1);
    tests++; if ({pos_x, pos_y} !== 8'h77 || busy !== 1'b0 || rd_en !== 1'b0 || step_index !== 8'd0) begin
      fails++; $display("FAIL mid_reset got (%0d,%0d) busy=%b rd_en=%b idx=%0d exp (7,7) 0 0 0", pos_x, pos_y, busy, rd_en, step_index);
    end
    reset_n = 1'b1;
    a0 = addr_log.size();
    cyc(3);
    tests++; if (addr_log.size() != a0) begin fails++; $display("FAIL mid_no_reads got %0d exp 0", addr_log.size() - a0); end
    do_start(8'd5);
    tests++; if (rd_en !== 1'b1 || rd_addr !== 8'd0) begin fails++; $display("FAIL mid_restart got rd_en=%b addr=%0d exp 1 0", rd_en, rd_addr); end
    for (int k = 0; k < 5; k++) begin
      cyc(4);
      pulse_tick();
    end
    cyc(1);
    tests++; if (done !== 1'b1 || {pos_x, pos_y} !== 8'hA9) begin fails++; $display("FAIL mid_replay got done=%b (%0d,%0d) exp done=1 (10,9)", done, pos_x, pos_y); end
    cyc(2);
  endtask

  initial begin
    test_reset();
    test_normal();
    test_saturation();
    test_zero_count();
    test_start_busy();
    test_tick_timing();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
